// File: rtl/zoom_pkg.sv
// zoom_pkg: mode/state encodings and per-mode beat counts for the zoom engine
package zoom_pkg;
    typedef enum logic [1:0] {
        MODE_COPY = 2'b00,
        MODE_REPL = 2'b01,
        MODE_AVG  = 2'b10,
        MODE_DEC  = 2'b11
    } mode_e;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_e;
    localparam int CPG_COPY = 3;
    localparam int CPG_REPL = 6;
    localparam int CPG_DEC  = 3;
    localparam int CPG_AVG  = 6;
`ifdef AVERAGE_MODE_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif
    // Each group spends one CAP cycle plus RD and WR beats; index of the last beat.
    function automatic logic [1:0] rd_last(mode_e m);
        return m == MODE_AVG ? 2'(CPG_AVG - 3) : 2'd0;
    endfunction
    function automatic logic [1:0] wr_last(mode_e m);
        return m == MODE_REPL ? 2'(CPG_REPL - 3) : m == MODE_COPY ? 2'(CPG_COPY - 3) : 2'(CPG_DEC - 3);
    endfunction
endpackage

// File: rtl/zoom_addr_gen.sv
// zoom_addr_gen: raster row/col counters and source/destination address decode
//   clock_i, reset_i  : clock, sync active-high reset
//   clr_i, step_i     : restart at pixel 0 / advance one raster position
//   mode_i, sub_i     : latched mode and beat index within the current group
//   last_o            : counters sit on the final position of the iterated grid
//   src_addr_o, dst_addr_o : decoded memory addresses
module zoom_addr_gen
    import zoom_pkg::*;
#(
    parameter int SRC_WIDTH  = 160,
    parameter int SRC_HEIGHT = 120,
    parameter int ADDR_W     = 17
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              step_i,
    input  mode_e             mode_i,
    input  logic [1:0]        sub_i,
    output logic              last_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o
);
    localparam logic [ADDR_W-1:0] W = ADDR_W'(SRC_WIDTH);
    localparam logic [ADDR_W-1:0] H = ADDR_W'(SRC_HEIGHT);
    logic              full, col_end;
    logic [ADDR_W-1:0] row_q, col_q, row_d, col_d, cols, rows, r2, c2;
    always_comb begin
        full       = mode_i == MODE_COPY || mode_i == MODE_REPL;
        cols       = full ? W : W >> 1;
        rows       = full ? H : H >> 1;
        col_end    = col_q == cols - 1'b1;
        last_o     = col_end && row_q == rows - 1'b1;
        col_d      = clr_i ? '0 : step_i ? (col_end ? '0 : col_q + 1'b1) : col_q;
        row_d      = clr_i ? '0 : step_i && col_end ? row_q + 1'b1 : row_q;
        r2         = (row_q << 1) + ADDR_W'(sub_i[1]);
        c2         = (col_q << 1) + ADDR_W'(sub_i[0]);
        src_addr_o = full ? row_q * W + col_q : r2 * W + c2;
        dst_addr_o = mode_i == MODE_COPY ? row_q * W + col_q :
                     mode_i == MODE_REPL ? r2 * (W << 1) + c2 : row_q * (W >> 1) + col_q;
    end
    always_ff @(posedge clock_i) begin
        row_q <= reset_i ? '0 : row_d;
        col_q <= reset_i ? '0 : col_d;
    end
endmodule

// File: rtl/zoom_controller.sv
// zoom_controller: memory-backed copy/replicate/decimate/average frame scaler
//   clock_i, reset_i        : clock, sync active-high reset
//   start_i, mode_i         : command strobe and operation, sampled in IDLE
//   busy_o, done_o, err_o   : status; err_o pulses with done_o for an unsupported mode
//   src_rd_en_o/addr_o, src_rd_data_i     : source RAM port, read latency 1
//   dst_wr_en_o/addr_o/data_o             : destination RAM write port
//   AVERAGE_MODE_EN : builds the 2x2 block average for mode 10; otherwise mode 10 is rejected
module zoom_controller
    import zoom_pkg::*;
#(
    parameter int SRC_WIDTH  = 160,
    parameter int SRC_HEIGHT = 120,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              src_rd_en_o,
    output logic [ADDR_W-1:0] src_rd_addr_o,
    input  logic [DATA_W-1:0] src_rd_data_i,
    output logic              dst_wr_en_o,
    output logic [ADDR_W-1:0] dst_wr_addr_o,
    output logic [DATA_W-1:0] dst_wr_data_o
);
    state_e            state_q;
    mode_e             mode_q;
    logic [1:0]        sub_q;
    logic              bad_q, last_px, accept, mode_ok, rd_done, wr_done, step;
    logic [DATA_W-1:0] cap_q;
    assign accept  = state_q == S_IDLE && start_i;
    assign mode_ok = AVG_EN || mode_i != MODE_AVG;
    assign rd_done = sub_q == rd_last(mode_q);
    assign wr_done = sub_q == wr_last(mode_q);
    assign step    = state_q == S_WR && wr_done && !last_px;
    zoom_addr_gen #(
        .SRC_WIDTH (SRC_WIDTH),
        .SRC_HEIGHT(SRC_HEIGHT),
        .ADDR_W    (ADDR_W)
    ) u_addr (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clr_i     (accept),
        .step_i    (step),
        .mode_i    (mode_q),
        .sub_i     (sub_q),
        .last_o    (last_px),
        .src_addr_o(src_rd_addr_o),
        .dst_addr_o(dst_wr_addr_o)
    );
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_COPY;
            sub_q   <= 2'd0;
            bad_q   <= 1'b0;
            cap_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    mode_q  <= mode_e'(mode_i);
                    bad_q   <= !mode_ok;
                    sub_q   <= 2'd0;
                    state_q <= mode_ok ? S_RD : S_DONE;
                end
                S_RD: begin
                    sub_q   <= rd_done ? 2'd0 : sub_q + 2'd1;
                    state_q <= rd_done ? S_CAP : S_RD;
                end
                S_CAP: begin
                    cap_q   <= src_rd_data_i;
                    state_q <= S_WR;
                end
                S_WR: begin
                    sub_q   <= wr_done ? 2'd0 : sub_q + 2'd1;
                    state_q <= !wr_done ? S_WR : last_px ? S_DONE : S_RD;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`ifdef AVERAGE_MODE_EN
    logic [DATA_W+1:0] acc_q;
    // Data for RD beat n arrives during beat n+1; the fourth datum lands in CAP.
    always_ff @(posedge clock_i) begin
        if (reset_i || (accept && mode_ok) || step)
            acc_q <= '0;
        else if (mode_q == MODE_AVG && ((state_q == S_RD && sub_q != 2'd0) || state_q == S_CAP))
            acc_q <= acc_q + {2'b00, src_rd_data_i};
    end
    assign dst_wr_data_o = mode_q == MODE_AVG ? acc_q[DATA_W+1:2] : cap_q;
`else
    assign dst_wr_data_o = cap_q;
`endif
    assign busy_o      = state_q != S_IDLE;
    assign done_o      = state_q == S_DONE;
    assign err_o       = done_o && bad_q;
    assign src_rd_en_o = state_q == S_RD;
    // A write in progress is suppressed in the very cycle reset is raised.
    assign dst_wr_en_o = state_q == S_WR && !reset_i;
endmodule

// File: tb/tb_zoom_controller.sv
// tb_zoom_controller: randomized and directed checks of zoom_controller against a frame-level model
module tb_zoom_controller;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NS = SW * SH;
    localparam int ND = 4 * SW * SH;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [1:0]    mode;
    logic          busy, done, err, src_rd_en, dst_wr_en;
    logic [AW-1:0] src_rd_addr, dst_wr_addr;
    logic [DW-1:0] src_rd_data = '0;
    logic [DW-1:0] dst_wr_data;

    logic [DW-1:0] src_mem [NS];
    logic [DW-1:0] dst_mem [ND];
    int            dst_gen [ND];
    int            wr_log  [4096];
    int            gen = 0;
    int            wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, done_cnt = 0, err_cnt = 0;
    int            bad_rd = 0, bad_wr = 0;
    int            checks = 0, failures = 0;
    int            exp_mem [ND];
    int            exp_n, exp_rd, exp_busy, exp_err, last_w0;

    zoom_controller #(
        .SRC_WIDTH (SW),
        .SRC_HEIGHT(SH),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .start_i      (start),
        .mode_i       (mode),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .src_rd_en_o  (src_rd_en),
        .src_rd_addr_o(src_rd_addr),
        .src_rd_data_i(src_rd_data),
        .dst_wr_en_o  (dst_wr_en),
        .dst_wr_addr_o(dst_wr_addr),
        .dst_wr_data_o(dst_wr_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (src_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (int'(src_rd_addr) < NS) src_rd_data <= src_mem[int'(src_rd_addr)];
            else bad_rd <= bad_rd + 1;
        end
        if (dst_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            wr_log[wr_cnt % 4096] <= int'(dst_wr_addr);
            if (int'(dst_wr_addr) < ND) begin
                dst_mem[int'(dst_wr_addr)] <= dst_wr_data;
                dst_gen[int'(dst_wr_addr)] <= gen;
            end else bad_wr <= bad_wr + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic fill_ramp();
        for (int i = 0; i < NS; i++) src_mem[i] = DW'(i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NS; i++) src_mem[i] = DW'($urandom);
    endtask

    // Expected destination frame and activity counts from the scaling rules.
    task automatic model(input int m);
        exp_err = 0; exp_n = 0; exp_rd = 0; exp_busy = 1;
        if (m == 0) begin
            exp_n = NS;
            for (int i = 0; i < NS; i++) exp_mem[i] = int'(src_mem[i]);
            exp_rd = NS; exp_busy = NS * 3 + 1;
        end else if (m == 1) begin
            exp_n = ND;
            for (int y = 0; y < 2 * SH; y++)
                for (int x = 0; x < 2 * SW; x++)
                    exp_mem[y * 2 * SW + x] = int'(src_mem[(y / 2) * SW + x / 2]);
            exp_rd = NS; exp_busy = NS * 6 + 1;
        end else if (m == 3) begin
            exp_n = NS / 4;
            for (int y = 0; y < SH / 2; y++)
                for (int x = 0; x < SW / 2; x++)
                    exp_mem[y * (SW / 2) + x] = int'(src_mem[2 * y * SW + 2 * x]);
            exp_rd = exp_n; exp_busy = exp_n * 3 + 1;
        end else begin
`ifdef AVERAGE_MODE_EN
            exp_n = NS / 4;
            for (int y = 0; y < SH / 2; y++)
                for (int x = 0; x < SW / 2; x++)
                    exp_mem[y * (SW / 2) + x] = (int'(src_mem[2 * y * SW + 2 * x]) + int'(src_mem[2 * y * SW + 2 * x + 1]) +
                                                 int'(src_mem[(2 * y + 1) * SW + 2 * x]) + int'(src_mem[(2 * y + 1) * SW + 2 * x + 1])) / 4;
            exp_rd = 4 * exp_n; exp_busy = exp_n * 6 + 1;
`else
            exp_err = 1;
`endif
        end
    endtask

    task automatic run_op(input int m, input bit mid_start, input string tag);
        int w0, r0, b0, d0, e0, cyc;
        bit seen;
        model(m);
        gen++;
        w0 = wr_cnt; r0 = rd_cnt; b0 = busy_cnt; d0 = done_cnt; e0 = err_cnt;
        last_w0 = w0; cyc = 0; seen = 0;
        @(negedge clock);
        start = 1'b1; mode = 2'(m);
        @(posedge clock);
        #1 start = 1'b0;
        checks++;
        if ({busy, src_rd_en, done, err} !== {1'b1, exp_rd != 0, exp_rd == 0, exp_rd == 0}) begin
            failures++;
            $display("FAIL %s accept_status busy/rd/done/err got=%b exp=%b", tag, {busy, src_rd_en, done, err},
                     {1'b1, exp_rd != 0, exp_rd == 0, exp_rd == 0});
        end
        while (!seen && cyc < 5000) begin
            @(negedge clock);
            if (mid_start && cyc == 20) begin
                start = 1'b1; mode = 2'd1;
            end else start = 1'b0;
            seen = done === 1'b1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s done_timeout got=no_done exp=done within 5000 cycles", tag);
        end
        @(posedge clock);
        #1;
        checks++;
        if (wr_cnt - w0 != exp_n) begin failures++; $display("FAIL %s write_count got=%0d exp=%0d", tag, wr_cnt - w0, exp_n); end
        checks++;
        if (rd_cnt - r0 != exp_rd) begin failures++; $display("FAIL %s read_count got=%0d exp=%0d", tag, rd_cnt - r0, exp_rd); end
        checks++;
        if (busy_cnt - b0 != exp_busy) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, busy_cnt - b0, exp_busy); end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s done_pulses got=%0d exp=1", tag, done_cnt - d0); end
        checks++;
        if (err_cnt - e0 != exp_err) begin failures++; $display("FAIL %s err_pulses got=%0d exp=%0d", tag, err_cnt - e0, exp_err); end
        checks++;
        if (bad_rd + bad_wr != 0) begin failures++; $display("FAIL %s out_of_range_access got=%0d exp=0", tag, bad_rd + bad_wr); end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (dst_gen[i] != gen || dst_mem[i] !== DW'(exp_mem[i])) begin
                failures++;
                $display("FAIL %s dst[%0d] got=%0d (written=%0d) exp=%0d", tag, i, dst_mem[i], dst_gen[i] == gen, exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, err, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=all zero", {busy, done, err, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data});
        end
        reset = 1'b0;
    endtask

    task automatic test_replicate();
        int ea [4];
        ea = '{0, 1, 2 * SW, 2 * SW + 1};
        fill_ramp();
        run_op(1, 1'b0, "replicate");
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_log[last_w0 + k] != ea[k]) begin
                failures++;
                $display("FAIL replicate write_order[%0d] got=%0d exp=%0d", k, wr_log[last_w0 + k], ea[k]);
            end
        end
    endtask

    task automatic test_decimate();
        fill_ramp();
        run_op(3, 1'b0, "decimate");
    endtask

    task automatic test_average();
        fill_ramp();
        run_op(2, 1'b0, "average");
    endtask

    task automatic test_copy_mid_start();
        fill_ramp();
        run_op(0, 1'b1, "copy_mid_start");
    endtask

    task automatic test_reset_mid();
        int w0, cyc, p, s, a;
        fill_ramp();
        model(1);
        gen++;
        w0 = wr_cnt; cyc = 0;
        @(negedge clock);
        start = 1'b1; mode = 2'd1;
        @(posedge clock);
        #1 start = 1'b0;
        while (wr_cnt - w0 < 10 && cyc < 500) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (wr_cnt - w0 != 10) begin failures++; $display("FAIL reset_mid reach_10_writes got=%0d exp=10", wr_cnt - w0); end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (dst_wr_en !== 1'b0) begin failures++; $display("FAIL reset_mid wr_en_in_reset_cycle got=%b exp=0", dst_wr_en); end
        @(posedge clock);
        #1 reset = 1'b0;
        checks++;
        if ({busy, done, err, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid outputs got=%b exp=all zero", {busy, done, err, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data});
        end
        repeat (20) @(posedge clock);
        #1;
        checks++;
        if (wr_cnt - w0 != 10) begin failures++; $display("FAIL reset_mid writes_after_reset got=%0d exp=10", wr_cnt - w0); end
        for (int k = 0; k < 10; k++) begin
            p = k / 4; s = k % 4;
            a = (2 * (p / SW) + s / 2) * 2 * SW + 2 * (p % SW) + s % 2;
            checks++;
            if (dst_gen[a] != gen || dst_mem[a] !== DW'(exp_mem[a])) begin
                failures++;
                $display("FAIL reset_mid partial dst[%0d] got=%0d (written=%0d) exp=%0d", a, dst_mem[a], dst_gen[a] == gen, exp_mem[a]);
            end
        end
        run_op(1, 1'b0, "replicate_after_reset");
        checks++;
        if (wr_log[last_w0] != 0) begin failures++; $display("FAIL replicate_after_reset first_addr got=%0d exp=0", wr_log[last_w0]); end
    endtask

    task automatic test_random();
        int m;
        for (int n = 0; n < 6; n++) begin
            fill_rand();
            m = int'($urandom_range(0, 3));
            run_op(m, 1'b0, $sformatf("random%0d_mode%0d", n, m));
        end
    endtask

    initial begin
        test_reset();
        test_replicate();
        test_decimate();
        test_average();
        test_copy_mid_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/zoom_controller.md
# zoom_controller

Sequencer for the image-scaling datapath. On a start command it walks a source frame held in synchronous RAM and writes a scaled frame to a destination RAM. The supported operations are 2x pixel replication (zoom-in), 2x decimation (zoom-out), plain copy and an optional 2x2 block average. It sits between the command interface (switches/host) and the two frame memories, and replaces the fixed in-register replication with a memory-backed, mode-selectable engine.

## Interface
- SRC_WIDTH, default 160: source image width in pixels; must be even.
- SRC_HEIGHT, default 120: source image height in pixels; must be even.
- ADDR_W, default 17: address width; must hold 4·SRC_WIDTH·SRC_HEIGHT−1.
- DATA_W, default 8: pixel width (grayscale).
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  2  operation: 00 copy, 01 replicate 2x, 10 average 2x down, 11 decimate 2x; sampled with start.
- busy  out  1  high from the cycle after start is accepted until DONE completes.
- done  out  1  one-cycle pulse at end of operation.
- err  out  1  one-cycle pulse coincident with done when the mode is unsupported.
- src_rd_en  out  1  source RAM read strobe.
- src_rd_addr  out  ADDR_W  source address, row·SRC_WIDTH+col.
- src_rd_data  in  DATA_W  source data, valid exactly one cycle after src_rd_en.
- dst_wr_en  out  1  destination write strobe.
- dst_wr_addr  out  ADDR_W  destination address, row·dst_width+col.
- dst_wr_data  out  DATA_W  destination data.

## Operation
- States: IDLE, RD, CAP, WR, DONE; mode is latched on accept.
- Accept rule: start=1 in IDLE. The next state is RD, or DONE when the mode is invalid.
- COPY (dst SRC_WIDTH×SRC_HEIGHT):
  - per pixel: RD (read), CAP (latch data), WR (one write).
- REPLICATE (dst 2·SRC_WIDTH × 2·SRC_HEIGHT):
  - per source pixel (r,c): RD, CAP, then WR for 4 cycles.
  - write order: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - data is the latched pixel in all four writes.
- DECIMATE (dst SRC_WIDTH/2 × SRC_HEIGHT/2):
  - per output pixel (r,c): read source (2r,2c), then CAP and a single WR.
- AVERAGE (dst SRC_WIDTH/2 × SRC_HEIGHT/2):
  - RD for 4 consecutive cycles, reading (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - each returned datum is added into a DATA_W+2-bit accumulator one cycle later. The final add happens in CAP.
  - WR writes accumulator[DATA_W+1:2] (truncating divide by 4); the accumulator clears on entry to RD.
- Traversal is raster order over the iterated grid (source grid for COPY/REPLICATE, output grid otherwise). Column wraps to 0 and the row increments; after the last row the next state is DONE.
- DONE: done=1 for one cycle, then IDLE. err=1 also when the mode was invalid; no memory access occurs in that case.
- start while busy is ignored and not queued.
- Outputs not qualified by an enable hold their previous value.

## Timing
- Reset value of every output: 0. State returns to IDLE and counters and accumulator are cleared.
- Reset mid-operation aborts at once: no write occurs in the reset cycle or afterwards; the partial frame is left as written.
- Accept at edge k: busy=1 and src_rd_en=1 in cycle k+1.
- Cycles per group: COPY 3, REPLICATE 6, DECIMATE 3, AVERAGE 6.
- busy duration: groups·cycles_per_group + 1 (DONE); done is asserted in the last busy cycle.
- Memory outputs are decoded from registered state and counters. No combinational path exists from src_rd_data to dst_wr_data except through the CAP/accumulator register.
- Read latency is fixed at 1; no back-pressure on either RAM.

## Configuration
- AVERAGE_MODE_EN defined: mode 10 performs the 2x2 block average as above.
- Not defined: the accumulator is not built. Mode 10 is invalid: the next cycle goes straight to DONE with done=1 and err=1, and there are no reads or writes.

## Structure
- Package zoom_pkg:
  - mode encodings (MODE_COPY, MODE_REPL, MODE_AVG, MODE_DEC)
  - FSM state enum
  - per-mode cycles-per-group constants
- Sub-module zoom_addr_gen:
  - holds the row/col raster counters with wrap and last-pixel flag
  - computes src_rd_addr and dst_wr_addr from counters, sub-step index and mode
  - the FSM in zoom_controller drives its step/clear inputs.

## Test plan
All scenarios use SRC 4×4 holding values 0..15 in raster order.
- REPLICATE: start, mode=01 → 64 writes; dst addresses 0..7 = 0,0,1,1,2,2,3,3 and 8..15 identical; busy lasts 97 cycles; done pulses once.
- DECIMATE: mode=11 → 4 writes, dst[0..3] = 0,2,8,10; busy 13 cycles.
- AVERAGE with AVERAGE_MODE_EN: mode=10 → dst[0..3] = 2,4,10,12. Without the macro: done=err=1 one cycle after accept, zero src_rd_en and dst_wr_en.
- COPY: mode=00 → dst equals src for all 16 addresses; a second start pulsed mid-run is ignored (exactly 16 writes, one done).
- Reset asserted on the 10th write of REPLICATE → all outputs 0 next cycle, no further writes; a new start after release runs normally from address 0.
